// File: rtl/cpu_pkg.sv
// cpu_pkg: stack operation encodings shared by decode and execute stages
package cpu_pkg;
  localparam logic [1:0] STK_NOP     = 2'b00;
  localparam logic [1:0] STK_PUSH    = 2'b01;
  localparam logic [1:0] STK_REPLACE = 2'b10;
  localparam logic [1:0] STK_POP     = 2'b11;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: stack storage with one synchronous write port and two asynchronous read ports
module stack_ram #(
  parameter int WIDTH       = 16,
  parameter int SADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [SADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [SADDR_WIDTH-1:0] raddr_a,
  output logic [WIDTH-1:0]       rdata_a,
  input  logic [SADDR_WIDTH-1:0] raddr_b,
  output logic [WIDTH-1:0]       rdata_b
);
  logic [WIDTH-1:0] mem [2**SADDR_WIDTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/stack_unit.sv
// stack_unit: parameter/return stack with occupancy, sticky error flags, optional wrap and peek port
module stack_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SADDR_WIDTH = 8,
  parameter int WRAP        = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             op,
  input  logic [WIDTH-1:0]       D,
  output logic [WIDTH-1:0]       Q,
  input  logic [SADDR_WIDTH-1:0] peek_idx,
  output logic [WIDTH-1:0]       peek_q,
  output logic                   peek_valid,
  output logic [SADDR_WIDTH:0]   count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic                   unf,
  input  logic                   err_clr
);
  localparam logic [SADDR_WIDTH:0] DEPTH = (SADDR_WIDTH+1)'(2**SADDR_WIDTH);

  logic [SADDR_WIDTH-1:0] ptr;
  logic [WIDTH-1:0]       top_raw, peek_raw;
  logic                   push_ok, pop_ok, rep_ok, ovf_ev, unf_ev;

  assign empty   = count == '0;
  assign full    = count == DEPTH;
  assign push_ok = op == STK_PUSH && (!full || WRAP != 0);
  assign ovf_ev  = op == STK_PUSH && full && WRAP == 0;
  assign pop_ok  = op == STK_POP && !empty;
  assign rep_ok  = op == STK_REPLACE && !empty;
  assign unf_ev  = (op == STK_POP || op == STK_REPLACE) && empty;

  stack_ram #(.WIDTH(WIDTH), .SADDR_WIDTH(SADDR_WIDTH)) u_ram (
    .clk     (clk),
    .we      ((push_ok || rep_ok) && !reset),
    .waddr   (push_ok ? ptr + 1'b1 : ptr),
    .wdata   (D),
    .raddr_a (ptr),
    .rdata_a (top_raw),
    .raddr_b (ptr - peek_idx),
    .rdata_b (peek_raw)
  );

  // empty/peek gating keeps stale storage off the outputs after reset or pops
  assign peek_valid = {1'b0, peek_idx} < count;
  assign Q          = empty ? '0 : top_raw;
  assign peek_q     = peek_valid ? peek_raw : '0;

  always_ff @(posedge clk)
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ptr   <= push_ok ? ptr + 1'b1 : pop_ok ? ptr - 1'b1 : ptr;
      count <= (push_ok && !full) ? count + 1'b1 : pop_ok ? count - 1'b1 : count;
      ovf   <= ovf_ev || (ovf && !err_clr);
      unf   <= unf_ev || (unf && !err_clr);
    end
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: random and directed checks of three stack_unit configurations against a queue-style model
module tb_stack_unit;
  import cpu_pkg::*;

  logic        clk = 0;
  logic        reset, err_clr;
  logic [1:0]  op;
  logic [15:0] D;
  logic [7:0]  pk;
  logic [1:0]  pk_s;

  logic [15:0] q_o [3];
  logic [15:0] pq_o [3];
  logic        pv_o [3], e_o [3], f_o [3], ov_o [3], un_o [3];
  logic [8:0]  c0;
  logic [2:0]  c1, c2;

  int n_chk = 0, n_fail = 0;

  localparam int DEP [3] = '{256, 4, 4};
  localparam bit WRP [3] = '{1'b0, 1'b0, 1'b1};

  logic [15:0] m [3][256];
  int          mcnt [3];
  bit          mo [3], mu [3];

  always #5 clk = ~clk;

  stack_unit #(.WIDTH(16), .SADDR_WIDTH(8), .WRAP(0)) u0 (
    .clk(clk), .reset(reset), .op(op), .D(D), .Q(q_o[0]), .peek_idx(pk), .peek_q(pq_o[0]),
    .peek_valid(pv_o[0]), .count(c0), .empty(e_o[0]), .full(f_o[0]), .ovf(ov_o[0]), .unf(un_o[0]),
    .err_clr(err_clr));
  stack_unit #(.WIDTH(16), .SADDR_WIDTH(2), .WRAP(0)) u1 (
    .clk(clk), .reset(reset), .op(op), .D(D), .Q(q_o[1]), .peek_idx(pk_s), .peek_q(pq_o[1]),
    .peek_valid(pv_o[1]), .count(c1), .empty(e_o[1]), .full(f_o[1]), .ovf(ov_o[1]), .unf(un_o[1]),
    .err_clr(err_clr));
  stack_unit #(.WIDTH(16), .SADDR_WIDTH(2), .WRAP(1)) u2 (
    .clk(clk), .reset(reset), .op(op), .D(D), .Q(q_o[2]), .peek_idx(pk_s), .peek_q(pq_o[2]),
    .peek_valid(pv_o[2]), .count(c2), .empty(e_o[2]), .full(f_o[2]), .ovf(ov_o[2]), .unf(un_o[2]),
    .err_clr(err_clr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input int i, input logic [1:0] o, input logic [15:0] d, input bit c, input bit r);
    bit eo, eu;
    eo = 0;
    eu = 0;
    if (r) begin
      mcnt[i] = 0;
      mo[i] = 0;
      mu[i] = 0;
      return;
    end
    if (o == STK_PUSH) begin
      if (mcnt[i] < DEP[i]) begin
        m[i][mcnt[i]] = d;
        mcnt[i]++;
      end else if (WRP[i]) begin
        for (int k = 0; k < DEP[i] - 1; k++) m[i][k] = m[i][k+1];
        m[i][DEP[i]-1] = d;
      end else eo = 1;
    end else if (o == STK_REPLACE) begin
      if (mcnt[i] == 0) eu = 1;
      else m[i][mcnt[i]-1] = d;
    end else if (o == STK_POP) begin
      if (mcnt[i] == 0) eu = 1;
      else mcnt[i]--;
    end
    mo[i] = eo || (mo[i] && !c);
    mu[i] = eu || (mu[i] && !c);
  endtask

  task automatic check_inst(input int i, input logic [31:0] cnt_got, input int idx);
    logic [15:0] eq, ep;
    eq = mcnt[i] > 0 ? m[i][mcnt[i]-1] : 16'h0;
    ep = idx < mcnt[i] ? m[i][mcnt[i]-1-idx] : 16'h0;
    check($sformatf("count%0d", i), cnt_got, mcnt[i]);
    check($sformatf("Q%0d", i), q_o[i], eq);
    check($sformatf("empty%0d", i), e_o[i], mcnt[i] == 0);
    check($sformatf("full%0d", i), f_o[i], mcnt[i] == DEP[i]);
    check($sformatf("ovf%0d", i), ov_o[i], mo[i]);
    check($sformatf("unf%0d", i), un_o[i], mu[i]);
    check($sformatf("peek_valid%0d[%0d]", i, idx), pv_o[i], idx < mcnt[i]);
    check($sformatf("peek_q%0d[%0d]", i, idx), pq_o[i], ep);
  endtask

  task automatic check_all();
    pk = 8'($urandom_range(0, 5) == 0 ? $urandom : $urandom_range(0, 7));
    pk_s = 2'($urandom);
    #1;
    check_inst(0, 32'(c0), int'(pk));
    check_inst(1, 32'(c1), int'(pk_s));
    check_inst(2, 32'(c2), int'(pk_s));
  endtask

  task automatic cyc(input logic [1:0] o, input logic [15:0] d, input bit c = 0, input bit r = 0);
    op = o;
    D = d;
    err_clr = c;
    reset = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model(i, o, d, c, r);
    #1;
    op = STK_NOP;
    err_clr = 0;
    reset = 0;
    check_all();
  endtask

  initial begin
    logic [1:0]  o;
    int          sel;
    op = STK_NOP; D = 0; err_clr = 0; reset = 1; pk = 0; pk_s = 0;
    cyc(STK_NOP, 0, 0, 1);
    check("reset_empty", e_o[0], 1);

    cyc(STK_PUSH, 16'h1111); cyc(STK_PUSH, 16'h2222); cyc(STK_PUSH, 16'h3333);
    check("push3_Q", q_o[0], 16'h3333);
    check("push3_count", 32'(c0), 3);
    pk = 2; #1;
    check("peek2_q", pq_o[0], 16'h1111);
    check("peek2_valid", pv_o[0], 1);
    pk = 3; #1;
    check("peek3_valid", pv_o[0], 0);
    check("peek3_q", pq_o[0], 0);

    cyc(STK_NOP, 0, 0, 1);
    cyc(STK_POP, 0);
    check("pop_empty_unf", un_o[0], 1);
    check("pop_empty_Q", q_o[0], 0);
    cyc(STK_REPLACE, 16'hBEEF);
    check("rep_empty_count", 32'(c0), 0);
    cyc(STK_NOP, 0, 1);
    check("clr_unf", un_o[0], 0);

    cyc(STK_NOP, 0, 0, 1);
    for (int k = 1; k <= 4; k++) cyc(STK_PUSH, 16'(k));
    check("small_full", f_o[1], 1);
    cyc(STK_PUSH, 16'd5);
    check("small_ovf", ov_o[1], 1);
    check("small_ovf_Q", q_o[1], 16'd4);
    check("small_ovf_count", 32'(c1), 4);
    for (int k = 3; k >= 1; k--) begin
      cyc(STK_POP, 0);
      check("small_pop_Q", q_o[1], 16'(k));
    end
    cyc(STK_POP, 0);
    check("small_pop_empty", e_o[1], 1);

    cyc(STK_NOP, 0, 0, 1);
    for (int k = 1; k <= 6; k++) cyc(STK_PUSH, 16'(k));
    check("wrap_count", 32'(c2), 4);
    check("wrap_Q", q_o[2], 16'd6);
    check("wrap_ovf", ov_o[2], 0);
    for (int k = 0; k < 4; k++) begin
      pk_s = 2'(k); #1;
      check("wrap_peek", pq_o[2], 16'(6 - k));
    end

    cyc(STK_NOP, 0, 0, 1);
    cyc(STK_POP, 0, 1);
    check("clr_vs_new_unf", un_o[0], 1);
    cyc(STK_PUSH, 16'h0001);
    cyc(STK_REPLACE, 16'h00AA);
    check("replace_Q", q_o[0], 16'h00AA);
    check("replace_count", 32'(c0), 1);

    cyc(STK_PUSH, 16'h1234); cyc(STK_PUSH, 16'h5678);
    cyc(STK_PUSH, 16'h9999, 0, 1);
    check("rst_mid_count", 32'(c0), 0);
    check("rst_mid_Q", q_o[0], 0);
    check("rst_mid_flags", {ov_o[0], un_o[0]}, 0);

    for (int k = 0; k < 260; k++) cyc(STK_PUSH, 16'($urandom));
    check("big_ovf", ov_o[0], 1);

    for (int k = 0; k < 3000; k++) begin
      sel = $urandom_range(0, 9);
      o = sel < 4 ? STK_PUSH : sel < 7 ? STK_POP : sel < 9 ? STK_REPLACE : STK_NOP;
      cyc(o, 16'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
